// File: rtl/psram_cmd_ctrl_if.sv
// Command-side and RAM-side bus bundle for psram_cmd_ctrl.
// The slave modport is the controller; the master modport is the upstream
// command source together with the external RAM.
interface psram_cmd_ctrl_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    // Command side
    logic              io_cmd_valid;
    logic [1:0]        io_cmd;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_wdata;
    logic              mem_cmd_done;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdata_valid;

    // External asynchronous RAM side
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_dq_out;
    logic              ram_dq_oe;
    logic [DATA_W-1:0] ram_dq_in;
    logic              ram_ce_n;
    logic              ram_oe_n;
    logic              ram_we_n;
    logic              ram_ub_n;
    logic              ram_lb_n;

    modport slave (
        input  io_cmd_valid, io_cmd, io_addr, io_wdata, ram_dq_in,
        output mem_cmd_done, mem_rdata, mem_rdata_valid,
        output ram_addr, ram_dq_out, ram_dq_oe,
        output ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n
    );

    modport master (
        output io_cmd_valid, io_cmd, io_addr, io_wdata, ram_dq_in,
        input  mem_cmd_done, mem_rdata, mem_rdata_valid,
        input  ram_addr, ram_dq_out, ram_dq_oe,
        input  ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n
    );
endinterface

// File: rtl/psram_cmd_ctrl.sv
// Single-command executor for an asynchronous SRAM/PSRAM 16-bit bus.
// Sequence per access: SETUP (1) -> ACCESS (N) -> HOLD (1) -> RECOVER (TURN).
// No-op skips the bus and only spends max(TURN_CYCLES,1) cycles in RECOVER.
module psram_cmd_ctrl #(
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16,
    parameter int WR_CYCLES   = 4,
    parameter int RD_CYCLES   = 4,
    parameter int TURN_CYCLES = 1
) (
    input logic                clk,
    input logic                rst_n,
    psram_cmd_ctrl_if.slave    bus
);

    // One shared down-counter serves ACCESS and RECOVER, so it is sized for the
    // longest of the two phases.
    localparam int ACC_MAX = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_MAX = (ACC_MAX > TURN_CYCLES) ? ACC_MAX : TURN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYCLES - 1);
    // Same value covers both post-HOLD recovery and the no-op's max(TURN,1) wait.
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'((TURN_CYCLES > 1) ? TURN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RECOVER} stateT;
    typedef enum logic [1:0] {CMD_CLEAR, CMD_WRITE, CMD_READ, CMD_NOP} cmdT;

    stateT             stateQ, stateD;
    cmdT               cmdQ;
    logic [CNT_W-1:0]  cntQ;
    logic [ADDR_W-1:0] addrQ;
    logic [DATA_W-1:0] wdataQ;
    logic [DATA_W-1:0] capQ;
    logic [DATA_W-1:0] rdataQ;
    logic              rdataValidQ;
    logic              isWr;
    logic              doneD, ceN, oeN, weN, byteN, dqOe;

    assign isWr = (cmdQ == CMD_WRITE) || (cmdQ == CMD_CLEAR);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    // Next-state decision.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (bus.io_cmd_valid) stateD = (bus.io_cmd == CMD_NOP) ? RECOVER : SETUP;
            SETUP:   stateD = ACCESS;
            ACCESS:  if (cntQ == '0) stateD = HOLD;
            HOLD:    stateD = (TURN_CYCLES == 0) ? IDLE : RECOVER;
            RECOVER: if (cntQ == '0) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    // Command latch, phase counter, read capture and completion data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmdQ        <= CMD_NOP;
            cntQ        <= '0;
            addrQ       <= '0;
            wdataQ      <= '0;
            capQ        <= '0;
            rdataQ      <= '0;
            rdataValidQ <= 1'b0;
        end else begin
            rdataValidQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (bus.io_cmd_valid) begin
                        cmdQ <= cmdT'(bus.io_cmd);
                        cntQ <= REC_LOAD;
                        // A no-op leaves the bus exactly as it was.
                        if (bus.io_cmd != CMD_NOP) addrQ <= bus.io_addr;
                        if (bus.io_cmd == CMD_WRITE) wdataQ <= bus.io_wdata;
                        if (bus.io_cmd == CMD_CLEAR) wdataQ <= '0;
                    end
                end
                SETUP: cntQ <= (cmdQ == CMD_READ) ? RD_LOAD : WR_LOAD;
                ACCESS: begin
                    if (cntQ != '0) cntQ <= cntQ - CNT_W'(1);
                    else if (cmdQ == CMD_READ) capQ <= bus.ram_dq_in;
                end
                HOLD: begin
                    cntQ <= REC_LOAD;
                    if (TURN_CYCLES == 0 && cmdQ == CMD_READ) begin
                        rdataQ      <= capQ;
                        rdataValidQ <= 1'b1;
                    end
                end
                RECOVER: begin
                    if (cntQ != '0) cntQ <= cntQ - CNT_W'(1);
                    else if (cmdQ == CMD_READ) begin
                        rdataQ      <= capQ;
                        rdataValidQ <= 1'b1;
                    end
                end
                default: begin
                    cntQ   <= '0;
                    addrQ  <= '0;
                    wdataQ <= '0;
                end
            endcase
        end
    end

    // Bus strobes and done flag decoded from the current phase.
    always_comb begin
        // NOTE: defaults come first so every path assigns every output and no latch is inferred.
        doneD = 1'b1;
        ceN   = 1'b1;
        oeN   = 1'b1;
        weN   = 1'b1;
        byteN = 1'b1;
        dqOe  = 1'b0;
        case (stateQ)
            SETUP, HOLD: begin
                doneD = 1'b0;
                ceN   = 1'b0;
                byteN = 1'b0;
                dqOe  = isWr;
            end
            ACCESS: begin
                doneD = 1'b0;
                ceN   = 1'b0;
                byteN = 1'b0;
                dqOe  = isWr;
                weN   = !isWr;
                oeN   = isWr;
            end
            RECOVER: doneD = 1'b0;
            default: ;
        endcase
    end

    assign bus.mem_cmd_done    = doneD;
    assign bus.mem_rdata       = rdataQ;
    assign bus.mem_rdata_valid = rdataValidQ;
    assign bus.ram_addr        = addrQ;
    assign bus.ram_dq_out      = wdataQ;
    assign bus.ram_dq_oe       = dqOe;
    assign bus.ram_ce_n        = ceN;
    assign bus.ram_oe_n        = oeN;
    assign bus.ram_we_n        = weN;
    assign bus.ram_ub_n        = byteN;
    assign bus.ram_lb_n        = byteN;

endmodule

// File: tb/tb_psram_cmd_ctrl.sv
// Self-checking bench for psram_cmd_ctrl: a behavioural RAM on the external
// bus, a reference memory map for expected read data, and per-command timing
// expectations derived from the access-length formulas.
module tb_psram_cmd_ctrl;

    localparam int ADDR_W      = 25;
    localparam int DATA_W      = 16;
    localparam int WR_CYCLES   = 4;
    localparam int RD_CYCLES   = 4;
    localparam int TURN_CYCLES = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    psram_cmd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus  ();
    psram_cmd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();

    psram_cmd_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYCLES(WR_CYCLES),
        .RD_CYCLES(RD_CYCLES), .TURN_CYCLES(TURN_CYCLES)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    // Second instance with no recovery time, used for the short no-op case.
    psram_cmd_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYCLES(WR_CYCLES),
        .RD_CYCLES(RD_CYCLES), .TURN_CYCLES(0)
    ) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    assign bus0.ram_dq_in = '0;

    int testCnt = 0;
    int failCnt = 0;

    // Behavioural RAM driven purely by the bus strobes.
    logic [15:0] ramMem [logic [24:0]];
    logic [24:0] wrAddrQ [$];
    logic [15:0] wrDataQ [$];
    logic        prevWeN = 1'b1;

    // Reference view of memory contents and the last completed read.
    logic [15:0] refMem [logic [24:0]];
    logic [15:0] lastRead = 16'h0;

    logic [24:0] pool [8] = '{25'h0, 25'h1, 25'h2, 25'h3, 25'h00ABCDE,
                              25'h1000000, 25'h1FFFFFF, 25'h0155555};

    int lowCyc;
    int sweepRefire;

    // External RAM: writes land while we_n is low, reads drive data while oe_n is low.
    always @(negedge clk) begin
        if (!bus.ram_ce_n && !bus.ram_we_n) begin
            ramMem[bus.ram_addr] = bus.ram_dq_out;
            if (prevWeN) begin
                wrAddrQ.push_back(bus.ram_addr);
                wrDataQ.push_back(bus.ram_dq_out);
            end
        end
        prevWeN = bus.ram_we_n;
        if (!bus.ram_ce_n && !bus.ram_oe_n)
            bus.ram_dq_in = ramMem.exists(bus.ram_addr) ? ramMem[bus.ram_addr] : 16'h0;
        else
            bus.ram_dq_in = 16'hDEAD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] refRead(input logic [24:0] a);
        return refMem.exists(a) ? refMem[a] : 16'h0;
    endfunction

    // Issue one command from IDLE, watch it to completion, check timing and data.
    task automatic runCmd(input logic [1:0] cmd, input logic [24:0] addr, input logic [15:0] wdata);
        int cyc, ceCyc, weCyc, oeCyc, weFirst, busErr, addrErr, earlyValid;
        bit isRead, isWrite, isNop;
        int n, expLow;
        logic [15:0] expData;
        isRead  = (cmd == 2'b10);
        isWrite = (cmd == 2'b01) || (cmd == 2'b00);
        isNop   = (cmd == 2'b11);
        n       = isRead ? RD_CYCLES : WR_CYCLES;
        expLow  = isNop ? ((TURN_CYCLES > 1) ? TURN_CYCLES : 1) : 2 + n + TURN_CYCLES;
        expData = (cmd == 2'b01) ? wdata : 16'h0;
        cyc = 0; ceCyc = 0; weCyc = 0; oeCyc = 0; weFirst = -1;
        busErr = 0; addrErr = 0; earlyValid = 0;

        bus.io_cmd_valid = 1'b1;
        bus.io_cmd       = cmd;
        bus.io_addr      = addr;
        bus.io_wdata     = wdata;
        tick();
        check("done_fall", bus.mem_cmd_done, 1'b0);
        // Inputs after acceptance must be ignored.
        bus.io_cmd_valid = 1'b0;
        bus.io_cmd       = 2'($urandom);
        bus.io_addr      = 25'($urandom);
        bus.io_wdata     = 16'($urandom);

        while (!bus.mem_cmd_done && cyc < 64) begin
            if (!bus.ram_ce_n) begin
                ceCyc++;
                if (bus.ram_addr !== addr) addrErr++;
                if (isWrite && (bus.ram_dq_oe !== 1'b1 || bus.ram_dq_out !== expData)) busErr++;
            end
            if (bus.ram_ub_n !== bus.ram_ce_n || bus.ram_lb_n !== bus.ram_ce_n) busErr++;
            if (!bus.ram_we_n) begin
                if (weFirst < 0) weFirst = cyc;
                weCyc++;
            end
            if (!bus.ram_oe_n) oeCyc++;
            if (bus.ram_dq_oe && !bus.ram_oe_n) busErr++;
            if (!isWrite && bus.ram_dq_oe) busErr++;
            if (bus.mem_rdata_valid) earlyValid++;
            cyc++;
            tick();
        end

        check("done_low_cycles", cyc, expLow);
        check("ce_low_cycles", ceCyc, isNop ? 0 : 2 + n);
        check("we_low_cycles", weCyc, isWrite ? WR_CYCLES : 0);
        check("oe_low_cycles", oeCyc, isRead ? RD_CYCLES : 0);
        check("we_start", weFirst, isWrite ? 1 : -1);
        check("bus_errors", busErr, 0);
        check("addr_errors", addrErr, 0);
        check("early_valid", earlyValid, 0);

        if (isRead)  lastRead = refRead(addr);
        if (isWrite) refMem[addr] = expData;
        check("rdata_valid", bus.mem_rdata_valid, isRead);
        check("rdata", bus.mem_rdata, lastRead);
        tick();
        check("rdata_valid_drop", bus.mem_rdata_valid, 1'b0);
        check("rdata_hold", bus.mem_rdata, lastRead);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.io_cmd_valid  = 1'b0;
        bus.io_cmd        = 2'b11;
        bus.io_addr       = '0;
        bus.io_wdata      = '0;
        bus0.io_cmd_valid = 1'b0;
        bus0.io_cmd       = 2'b11;
        bus0.io_addr      = '0;
        bus0.io_wdata     = '0;

        // Reset values while held in reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", bus.mem_cmd_done, 1'b1);
        check("rst_rdata", bus.mem_rdata, 16'h0);
        check("rst_rvalid", bus.mem_rdata_valid, 1'b0);
        check("rst_addr", bus.ram_addr, 25'h0);
        check("rst_dq_out", bus.ram_dq_out, 16'h0);
        check("rst_dq_oe", bus.ram_dq_oe, 1'b0);
        check("rst_strobes", {bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n, bus.ram_ub_n, bus.ram_lb_n}, 5'b11111);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_release_done", bus.mem_cmd_done, 1'b1);

        // Directed write, then read from a preloaded location.
        runCmd(2'b01, 25'h00ABCDE, 16'hBEEF);
        check("ram_after_write", ramMem[25'h00ABCDE], 16'hBEEF);
        ramMem[25'h1000000] = 16'h1234;
        refMem[25'h1000000] = 16'h1234;
        runCmd(2'b10, 25'h1000000, 16'h5555);
        check("read_1234", lastRead, 16'h1234);
        runCmd(2'b11, 25'h1FFFFFF, 16'h7777);

        // Back-to-back clears with valid held high and the address advancing.
        wrAddrQ.delete();
        wrDataQ.delete();
        bus.io_cmd_valid = 1'b1;
        bus.io_cmd       = 2'b00;
        bus.io_wdata     = 16'hFFFF;
        bus.io_addr      = 25'h0;
        sweepRefire      = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.mem_cmd_done !== 1'b0) sweepRefire++;
            lowCyc = 0;
            while (!bus.mem_cmd_done && lowCyc < 64) begin
                lowCyc++;
                tick();
            end
            check("sweep_low_cycles", lowCyc, 2 + WR_CYCLES + TURN_CYCLES);
            refMem[25'(k)] = 16'h0;
            bus.io_addr = 25'(k + 1);
        end
        bus.io_cmd_valid = 1'b0;
        check("sweep_refire", sweepRefire, 0);
        check("sweep_write_count", wrAddrQ.size(), 4);
        for (int k = 0; k < 4 && k < wrAddrQ.size(); k++) begin
            check("sweep_addr", wrAddrQ[k], 25'(k));
            check("sweep_data", wrDataQ[k], 16'h0);
        end
        tick();
        check("sweep_idle", bus.mem_cmd_done, 1'b1);

        // No-op with zero recovery: a single busy cycle, no bus activity.
        bus0.io_cmd_valid = 1'b1;
        bus0.io_cmd       = 2'b11;
        bus0.io_addr      = 25'h1234567;
        bus0.io_wdata     = 16'hCAFE;
        tick();
        check("nop0_done_low", bus0.mem_cmd_done, 1'b0);
        check("nop0_strobes", {bus0.ram_ce_n, bus0.ram_oe_n, bus0.ram_we_n, bus0.ram_ub_n, bus0.ram_lb_n}, 5'b11111);
        check("nop0_addr", bus0.ram_addr, 25'h0);
        bus0.io_cmd_valid = 1'b0;
        bus0.io_cmd       = 2'b01;
        tick();
        check("nop0_done_back", bus0.mem_cmd_done, 1'b1);
        tick();
        check("nop0_still_idle", bus0.mem_cmd_done, 1'b1);
        check("nop0_no_strobes", {bus0.ram_ce_n, bus0.ram_we_n, bus0.ram_dq_oe}, 3'b110);

        // Randomised command mix against the reference memory.
        for (int i = 0; i < 16; i++) begin
            runCmd(2'($urandom_range(0, 3)), pool[$urandom_range(0, 7)], 16'($urandom));
        end

        // Reset in the second ACCESS cycle of a write.
        bus.io_cmd_valid = 1'b1;
        bus.io_cmd       = 2'b01;
        bus.io_addr      = 25'h0000F00;
        bus.io_wdata     = 16'hA5A5;
        tick();
        bus.io_cmd_valid = 1'b0;
        tick();
        tick();
        check("abort_we_low", bus.ram_we_n, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_strobes", {bus.ram_ce_n, bus.ram_oe_n, bus.ram_we_n, bus.ram_ub_n, bus.ram_lb_n}, 5'b11111);
        check("abort_done", bus.mem_cmd_done, 1'b1);
        check("abort_dq_oe", bus.ram_dq_oe, 1'b0);
        check("abort_addr", bus.ram_addr, 25'h0);
        check("abort_rvalid", bus.mem_rdata_valid, 1'b0);
        lastRead = 16'h0;
        tick();
        check("abort_rvalid_hold", bus.mem_rdata_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("abort_release_rvalid", bus.mem_rdata_valid, 1'b0);
        check("abort_release_done", bus.mem_cmd_done, 1'b1);
        runCmd(2'b10, 25'h00ABCDE, 16'h0);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
